// File: rtl/overlay_pkg.sv
// overlay_pkg -- shared constants, FSM state type and the per-channel blend
// helper for the overlay mixer.
//
// Build option: OVERLAY_FADE_EN (when defined, the weighted blend helper is
// compiled in; without it the mixer only switches between bg and ov).
package overlay_pkg;

    // Emblem pixels with this value show the background through.
    localparam logic [5:0] COLOR_TRANSPARENT = 6'b100001;
    localparam logic [5:0] COLOR_BLACK       = 6'b000000;

    // Blend level at which the overlay is fully opaque.
    localparam logic [2:0] FADE_LEVEL_MAX    = 3'd4;

    typedef enum logic [1:0] {
        ST_HIDDEN   = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_SHOWN    = 2'd2,
        ST_FADE_OUT = 2'd3
    } fade_state_t;

`ifdef OVERLAY_FADE_EN
    // One 2-bit channel: (ov*L + bg*(4-L)) >> 2. The sum never exceeds
    // 3*4 = 12, so a 4-bit accumulator holds it without saturation.
    function automatic logic [1:0] blend_channel(input logic [1:0] ov_c,
                                                 input logic [1:0] bg_c,
                                                 input logic [2:0] lvl);
        logic [3:0] w_ov;
        logic [3:0] w_bg;
        logic [3:0] acc;
        w_ov = 4'({2'b00, ov_c} * {1'b0, lvl});
        w_bg = 4'({2'b00, bg_c} * {1'b0, 3'(FADE_LEVEL_MAX - lvl)});
        acc  = w_ov + w_bg;
        return acc[3:2];
    endfunction
`endif

endpackage

// File: rtl/overlay_blend.sv
// overlay_blend -- combinational per-pixel mix of overlay over background.
//
// Ports:
//   bg    [5:0] in   background pixel, RRGGBB
//   ov    [5:0] in   overlay pixel, RRGGBB (COLOR_TRANSPARENT = see-through)
//   level [2:0] in   blend level 0..4 (4 = overlay only)
//   rgb   [5:0] out  mixed pixel
//
// Build option: OVERLAY_FADE_EN selects the weighted blend; otherwise the
// output is a plain mux (ov at level 4, bg at any other level).
module overlay_blend
    import overlay_pkg::*;
(
    input  logic [5:0] bg,
    input  logic [5:0] ov,
    input  logic [2:0] level,
    output logic [5:0] rgb
);

    logic [5:0] mixed;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
`ifdef OVERLAY_FADE_EN
            assign mixed[gi*2 +: 2] = blend_channel(ov[gi*2 +: 2], bg[gi*2 +: 2], level);
`else
            assign mixed[gi*2 +: 2] = (level == FADE_LEVEL_MAX) ? ov[gi*2 +: 2]
                                                                : bg[gi*2 +: 2];
`endif
        end
    endgenerate

    // Transparent emblem pixels always show the background untouched.
    assign rgb = (ov == COLOR_TRANSPARENT) ? bg : mixed;

endmodule

// File: rtl/overlay_mixer.sv
// overlay_mixer -- two-stage pipeline that mixes an emblem overlay over the
// background video and fades it in/out on frame boundaries.
//
// Ports:
//   clk           in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   in_hsync      in   active-low horizontal sync
//   in_vsync      in   active-low vertical sync
//   in_active     in   high inside the visible area
//   bg_rgb  [5:0] in   background pixel, RRGGBB
//   ov_rgb  [5:0] in   overlay pixel, RRGGBB (6'b100001 = transparent)
//   ov_enable     in   request to show the overlay
//   out_hsync     out  in_hsync delayed 2 clocks
//   out_vsync     out  in_vsync delayed 2 clocks
//   out_rgb [5:0] out  mixed pixel, 2 clocks after its inputs; black outside
//                      the active area
//   fade_level [2:0] out  current blend level 0..4
//
// Build option: OVERLAY_FADE_EN compiles in the fade FSM, the frame step
// counter and the weighted blend. Without it the level jumps straight to
// 0 or 4 on each frame tick from ov_enable.
module overlay_mixer
    import overlay_pkg::*;
#(
    parameter int FADE_STEP_FRAMES = 8,
    parameter int PIPE_LATENCY     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic       in_active,
    input  logic [5:0] bg_rgb,
    input  logic [5:0] ov_rgb,
    input  logic       ov_enable,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic [5:0] out_rgb,
    output logic [2:0] fade_level
);

    // Stage 1 registers.
    logic [5:0] s1_bg;
    logic [5:0] s1_ov;
    logic       s1_hs;
    logic       s1_vs;
    logic       s1_act;
    logic       vs_prev;

    logic       frame_tick;
    logic [5:0] blend_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_bg     <= '0;
            s1_ov     <= '0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_act    <= 1'b0;
            vs_prev   <= 1'b1;
            out_rgb   <= COLOR_BLACK;
            out_hsync <= 1'b1;
            out_vsync <= 1'b1;
        end else begin
            s1_bg     <= bg_rgb;
            s1_ov     <= ov_rgb;
            s1_hs     <= in_hsync;
            s1_vs     <= in_vsync;
            s1_act    <= in_active;
            vs_prev   <= s1_vs;
            out_rgb   <= s1_act ? blend_rgb : COLOR_BLACK;
            out_hsync <= s1_hs;
            out_vsync <= s1_vs;
        end
    end

    // Start of vertical sync pulse on the registered copy of vsync. The
    // level therefore only moves during vertical sync, never mid-frame.
    assign frame_tick = vs_prev & ~s1_vs;

    overlay_blend u_blend (
        .bg    (s1_bg),
        .ov    (s1_ov),
        .level (fade_level),
        .rgb   (blend_rgb)
    );

`ifdef OVERLAY_FADE_EN
    localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

    fade_state_t state_reg;
    logic [7:0]  step_cnt_reg;
    logic        step_last;

    assign step_last = (step_cnt_reg == STEP_LAST);

    // Each tick either reverses direction (counter restarts, level kept) or
    // advances the counter; a full count moves the level one step, clamped
    // to 0..4 even when a reversal happened right at an end point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_HIDDEN;
            step_cnt_reg <= '0;
            fade_level   <= '0;
        end else if (frame_tick) begin
            case (state_reg)
                ST_HIDDEN: begin
                    if (ov_enable) begin
                        state_reg    <= ST_FADE_IN;
                        step_cnt_reg <= '0;
                    end
                end
                ST_SHOWN: begin
                    if (!ov_enable) begin
                        state_reg    <= ST_FADE_OUT;
                        step_cnt_reg <= '0;
                    end
                end
                ST_FADE_IN: begin
                    if (!ov_enable) begin
                        state_reg    <= ST_FADE_OUT;
                        step_cnt_reg <= '0;
                    end else if (step_last) begin
                        step_cnt_reg <= '0;
                        if (fade_level >= 3'(FADE_LEVEL_MAX - 3'd1)) begin
                            fade_level <= FADE_LEVEL_MAX;
                            state_reg  <= ST_SHOWN;
                        end else begin
                            fade_level <= fade_level + 3'd1;
                        end
                    end else begin
                        step_cnt_reg <= step_cnt_reg + 8'd1;
                    end
                end
                ST_FADE_OUT: begin
                    if (ov_enable) begin
                        state_reg    <= ST_FADE_IN;
                        step_cnt_reg <= '0;
                    end else if (step_last) begin
                        step_cnt_reg <= '0;
                        if (fade_level <= 3'd1) begin
                            fade_level <= 3'd0;
                            state_reg  <= ST_HIDDEN;
                        end else begin
                            fade_level <= fade_level - 3'd1;
                        end
                    end else begin
                        step_cnt_reg <= step_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg    <= ST_HIDDEN;
                    step_cnt_reg <= '0;
                    fade_level   <= '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_level <= '0;
        end else if (frame_tick) begin
            fade_level <= ov_enable ? FADE_LEVEL_MAX : 3'd0;
        end
    end
`endif

endmodule

// File: tb/tb_overlay_mixer.sv
module tb_overlay_mixer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_active;
    logic [5:0] bg_rgb;
    logic [5:0] ov_rgb;
    logic       ov_enable;
    logic       out_hsync;
    logic       out_vsync;
    logic [5:0] out_rgb;
    logic [2:0] fade_level;

    int tests_run = 0;
    int tests_failed = 0;

    overlay_mixer #(
        .FADE_STEP_FRAMES (8),
        .PIPE_LATENCY     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .in_active  (in_active),
        .bg_rgb     (bg_rgb),
        .ov_rgb     (ov_rgb),
        .ov_enable  (ov_enable),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync),
        .out_rgb    (out_rgb),
        .fade_level (fade_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] bg;
        logic [5:0] ov;
        logic       hs;
        logic       vs;
        logic       act;
        logic [5:0] exp0;   // expected out_rgb at level 0
        logic [5:0] exp4;   // expected out_rgb at level 4
    } vec_t;

    localparam int NVEC = 5;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end else begin
            $display("ok   %s: %b", name, got);
        end
    endtask

    // One frame: vsync low 4 clocks, high 8 clocks. Level is sampled twice
    // after the tick has landed, to show it stays put for the frame.
    task automatic frame(output logic [2:0] l_a, output logic [2:0] l_b);
        in_vsync = 1'b0;
        repeat (4) @(negedge clk);
        in_vsync = 1'b1;
        repeat (2) @(negedge clk);
        l_a = fade_level;
        repeat (6) @(negedge clk);
        l_b = fade_level;
    endtask

    // Stream the table one vector per clock; output of vector i is checked
    // exactly two clocks after it was driven.
    task automatic run_table(input bit at_max);
        vec_t v;
        for (int i = 0; i < NVEC + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                v = vecs[i-2];
                check($sformatf("tbl%0d L%0d rgb", i-2, at_max ? 4 : 0),
                      {2'b00, out_rgb}, {2'b00, at_max ? v.exp4 : v.exp0});
                check($sformatf("tbl%0d hsync", i-2), {7'd0, out_hsync}, {7'd0, v.hs});
                check($sformatf("tbl%0d vsync", i-2), {7'd0, out_vsync}, {7'd0, v.vs});
            end
            if (i < NVEC) begin
                bg_rgb = vecs[i].bg; ov_rgb = vecs[i].ov;
                in_hsync = vecs[i].hs; in_vsync = vecs[i].vs; in_active = vecs[i].act;
            end else begin
                in_hsync = 1'b1; in_vsync = 1'b1; in_active = 1'b0;
            end
        end
    endtask

    task automatic pixel(input logic [5:0] bg, input logic [5:0] ov);
        bg_rgb = bg; ov_rgb = ov; in_active = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [2:0] la, lb;

    initial begin
        vecs[0] = '{bg:6'b000000, ov:6'b110110, hs:1'b0, vs:1'b1, act:1'b1, exp0:6'b000000, exp4:6'b110110};
        vecs[1] = '{bg:6'b010101, ov:6'b100001, hs:1'b1, vs:1'b0, act:1'b1, exp0:6'b010101, exp4:6'b010101};
        vecs[2] = '{bg:6'b111111, ov:6'b110110, hs:1'b0, vs:1'b0, act:1'b0, exp0:6'b000000, exp4:6'b000000};
        vecs[3] = '{bg:6'b111111, ov:6'b000000, hs:1'b1, vs:1'b1, act:1'b1, exp0:6'b111111, exp4:6'b000000};
        vecs[4] = '{bg:6'b001100, ov:6'b101010, hs:1'b0, vs:1'b1, act:1'b1, exp0:6'b001100, exp4:6'b101010};

        rst_n = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1; in_active = 1'b0;
        bg_rgb = 6'b010101; ov_rgb = 6'b110110; ov_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst out_rgb", {2'b00, out_rgb}, 8'd0);
        check("rst out_hsync", {7'd0, out_hsync}, 8'd1);
        check("rst out_vsync", {7'd0, out_vsync}, 8'd1);
        check("rst fade_level", {5'd0, fade_level}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Level 0: background passes through.
        run_table(1'b0);

        ov_enable = 1'b1;
        repeat (4) @(negedge clk);
        check("no tick no change", {5'd0, fade_level}, 8'd0);

`ifdef OVERLAY_FADE_EN
        // Entry tick moves HIDDEN -> FADE_IN, level still 0.
        frame(la, lb);
        check("fade entry", {5'd0, lb}, 8'd0);
        // Then one level step every 8 ticks: after k ticks level = k/8.
        for (int k = 1; k <= 32; k++) begin
            frame(la, lb);
            if (k % 8 == 0 || k == 1)
                check($sformatf("fade_in tick%0d", k), {5'd0, lb}, 8'(k / 8));
            if (la !== lb) begin
                tests_run++; tests_failed++;
                $display("FAIL midframe tick%0d: got %0d then %0d expected constant", k, la, lb);
            end
        end
`else
        frame(la, lb);
        check("mux tick on", {5'd0, lb}, 8'd4);
`endif

        // Level 4: overlay replaces background except where transparent.
        run_table(1'b1);

`ifdef OVERLAY_FADE_EN
        // Fade to level 2, check the weighted blend, then reverse.
        do_reset();
        ov_enable = 1'b1;
        frame(la, lb);
        for (int k = 1; k <= 16; k++) frame(la, lb);
        check("reach L2", {5'd0, fade_level}, 8'd2);
        pixel(6'b000000, 6'b110110);
        check("blend L2 a", {2'b00, out_rgb}, 8'b00010001);
        pixel(6'b111111, 6'b000000);
        check("blend L2 b", {2'b00, out_rgb}, 8'b00010101);
        pixel(6'b010101, 6'b100001);
        check("blend L2 transparent", {2'b00, out_rgb}, 8'b00010101);

        ov_enable = 1'b0;
        frame(la, lb);
        check("fade_out entry keeps L", {5'd0, lb}, 8'd2);
        for (int k = 1; k <= 16; k++) begin
            frame(la, lb);
            if (k % 8 == 0)
                check($sformatf("fade_out tick%0d", k), {5'd0, lb}, 8'(2 - k / 8));
        end
        frame(la, lb);
        check("hidden stays 0", {5'd0, lb}, 8'd0);

        // Fade to level 3 for the reset-mid-fade case.
        do_reset();
        ov_enable = 1'b1;
        frame(la, lb);
        for (int k = 1; k <= 24; k++) frame(la, lb);
        check("reach L3", {5'd0, fade_level}, 8'd3);
        pixel(6'b000000, 6'b110110);
        check("blend L3", {2'b00, out_rgb}, 8'b00100001);
`else
        pixel(6'b000000, 6'b110110);
`endif

        // Asynchronous reset mid-line: outputs must drop without a clock edge.
        in_hsync = 1'b0;
        bg_rgb = 6'b010101; ov_rgb = 6'b110110;
        repeat (2) @(negedge clk);
        check("pre-reset hsync low", {7'd0, out_hsync}, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_rgb", {2'b00, out_rgb}, 8'd0);
        check("async rst out_hsync", {7'd0, out_hsync}, 8'd1);
        check("async rst out_vsync", {7'd0, out_vsync}, 8'd1);
        check("async rst fade_level", {5'd0, fade_level}, 8'd0);
        in_hsync = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after rst out=bg", {2'b00, out_rgb}, 8'b00010101);
        check("after rst L0", {5'd0, fade_level}, 8'd0);

        frame(la, lb);
`ifdef OVERLAY_FADE_EN
        check("restart entry L0", {5'd0, lb}, 8'd0);
        pixel(6'b010101, 6'b110110);
        check("restart out=bg", {2'b00, out_rgb}, 8'b00010101);
`else
        check("restart tick L4", {5'd0, lb}, 8'd4);
        pixel(6'b010101, 6'b110110);
        check("restart out=ov", {2'b00, out_rgb}, 8'b00110110);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
